// File: rtl/cnn_mac_pkg.sv
// cnn_mac_pkg: shared limits and saturation bounds for the pipelined MAC.
package cnn_mac_pkg;
  localparam int MUL_STAGES_MIN = 1;
  localparam int MUL_STAGES_MAX = 4;
  localparam int ACC_WIDTH_MAX = 64;
  function automatic logic [63:0] sat_max(input int w, input bit s);
    return s ? (64'd1 << (w - 1)) - 64'd1 : (w >= 64 ? '1 : (64'd1 << w) - 64'd1);
  endfunction
  function automatic logic [63:0] sat_min(input int w, input bit s);
    return s ? ~((64'd1 << (w - 1)) - 64'd1) : '0;
  endfunction
endpackage

// File: rtl/cnn_mac_pipe_mul.sv
// cnn_mac_pipe_mul: registered-operand multiplier with MUL_STAGES product registers and matching flag pipeline.
module cnn_mac_pipe_mul
  import cnn_mac_pkg::*;
#(
  parameter int A_WIDTH = 11,
  parameter int B_WIDTH = 9,
  parameter int MUL_STAGES = 2,
  parameter int SIGNED = 0,
  parameter int FLAG_W = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic [FLAG_W-1:0]          flags_in,
  output logic [A_WIDTH+B_WIDTH-1:0] p,
  output logic [FLAG_W-1:0]          flags_out
);
  localparam int PW = A_WIDTH + B_WIDTH;
  if (MUL_STAGES < MUL_STAGES_MIN || MUL_STAGES > MUL_STAGES_MAX) begin : g_bad_stages
    $error("cnn_mac_pipe_mul: MUL_STAGES out of range");
  end
  logic [A_WIDTH-1:0] a_r;
  logic [B_WIDTH-1:0] b_r;
  logic [FLAG_W-1:0]  f_in_r;
  logic [PW-1:0]      ae, be;
  logic [PW-1:0]      p_r [MUL_STAGES];
  logic [FLAG_W-1:0]  f_r [MUL_STAGES];
  // Extending both operands to the full product width keeps the low PW bits exact for either signedness
  assign ae = {{B_WIDTH{SIGNED != 0 && a_r[A_WIDTH-1]}}, a_r};
  assign be = {{A_WIDTH{SIGNED != 0 && b_r[B_WIDTH-1]}}, b_r};
  always_ff @(posedge clk)
    if (ce) begin
      a_r <= a;
      b_r <= b;
      p_r[0] <= ae * be;
      for (int i = 1; i < MUL_STAGES; i++) p_r[i] <= p_r[i-1];
    end
  always_ff @(posedge clk)
    if (rst) begin
      f_in_r <= '0;
      for (int i = 0; i < MUL_STAGES; i++) f_r[i] <= '0;
    end else if (ce) begin
      f_in_r <= flags_in;
      f_r[0] <= f_in_r;
      for (int i = 1; i < MUL_STAGES; i++) f_r[i] <= f_r[i-1];
    end
  assign p = p_r[MUL_STAGES-1];
  assign flags_out = f_r[MUL_STAGES-1];
endmodule

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined multiply feeding a saturating framed accumulator.
module cnn_mac_pipe
  import cnn_mac_pkg::*;
#(
  parameter int A_WIDTH = 11,
  parameter int B_WIDTH = 9,
  parameter int ACC_WIDTH = 24,
  parameter int MUL_STAGES = 2,
  parameter int SIGNED = 0
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [A_WIDTH-1:0]   din0,
  input  logic [B_WIDTH-1:0]   din1,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] dout,
  output logic                 out_ovf
);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam bit SGN = SIGNED != 0;
  localparam logic [63:0] SAT_MAX64 = sat_max(ACC_WIDTH, SGN);
  localparam logic [63:0] SAT_MIN64 = sat_min(ACC_WIDTH, SGN);
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = SAT_MAX64[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = SAT_MIN64[ACC_WIDTH-1:0];
  if (ACC_WIDTH < PW || ACC_WIDTH > ACC_WIDTH_MAX) begin : g_bad_acc
    $error("cnn_mac_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH and <= 64");
  end
  logic [PW-1:0]        p;
  logic [2:0]           flags;
  logic [ACC_WIDTH-1:0] pe, acc, base, nacc;
  logic [ACC_WIDTH:0]   sum;
  logic                 ovf, ovf_now, novf;
  // flags = {valid, first, last}, first/last pre-qualified by valid
  cnn_mac_pipe_mul #(
    .A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .MUL_STAGES(MUL_STAGES), .SIGNED(SIGNED), .FLAG_W(3)
  ) u_mul (
    .clk(ap_clk),
    .rst(ap_rst),
    .ce(ce),
    .a(din0),
    .b(din1),
    .flags_in({in_valid, in_valid & in_first, in_valid & in_last}),
    .p(p),
    .flags_out(flags)
  );
  if (ACC_WIDTH > PW) begin : g_ext
    assign pe = {{(ACC_WIDTH-PW){SGN && p[PW-1]}}, p};
  end else begin : g_noext
    assign pe = p;
  end
  // A first product starts from zero, so it can never overflow and needs no separate path
  assign base = flags[1] ? '0 : acc;
  assign sum = {SGN && base[ACC_WIDTH-1], base} + {SGN && pe[ACC_WIDTH-1], pe};
  assign ovf_now = SGN ? sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1] : sum[ACC_WIDTH];
  assign nacc = ovf_now ? (SGN && sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX) : sum[ACC_WIDTH-1:0];
  assign novf = (!flags[1] && ovf) | ovf_now;
  always_ff @(posedge ap_clk)
    if (ap_rst) begin
      acc <= '0;
      ovf <= 1'b0;
      dout <= '0;
      out_ovf <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= flags[2] && flags[0];
      if (flags[2]) begin
        acc <= flags[0] ? '0 : nacc;
        ovf <= !flags[0] && novf;
        if (flags[0]) begin
          dout <= nacc;
          out_ovf <= novf;
        end
      end
    end
endmodule

// File: tb/tb_cnn_mac_pipe.sv
// tb_cnn_mac_pipe: directed checks of the MAC across default, signed and 1/4-stage builds.
module tb_cnn_mac_pipe;
  logic ap_clk = 1'b0, ap_rst = 1'b1, ce = 1'b1;
  logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic [10:0] din0 = '0;
  logic [8:0] din1 = '0;
  logic ov_d, ovf_d, ov_s, ovf_s, ov_1, ovf_1, ov_4, ovf_4;
  logic [23:0] dout_d, dout_s, dout_1, dout_4;
  int errors = 0, checks = 0;
  always #5 ap_clk = ~ap_clk;
  cnn_mac_pipe dut_d (.ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov_d), .dout(dout_d), .out_ovf(ovf_d));
  cnn_mac_pipe #(.SIGNED(1)) dut_s (.ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov_s), .dout(dout_s),
    .out_ovf(ovf_s));
  cnn_mac_pipe #(.MUL_STAGES(1)) dut_1 (.ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov_1), .dout(dout_1),
    .out_ovf(ovf_1));
  cnn_mac_pipe #(.MUL_STAGES(4)) dut_4 (.ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid),
    .in_first(in_first), .in_last(in_last), .din0(din0), .din1(din1), .out_valid(ov_4), .dout(dout_4),
    .out_ovf(ovf_4));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ap_clk);
      #1;
    end
  endtask
  task automatic push(input logic f, input logic l, input logic [10:0] a, input logic [8:0] b);
    in_valid = 1'b1;
    in_first = f;
    in_last = l;
    din0 = a;
    din1 = b;
    tick(1);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic wait_out(input bit sgn, input int max);
    for (int i = 0; i < max && !(sgn ? ov_s : ov_d); i++) tick(1);
    chk(sgn ? "wait_out_s" : "wait_out_d", sgn ? ov_s : ov_d, 1);
  endtask
  initial begin
    tick(2);
    ap_rst = 1'b0;
    chk("rst_valid", ov_d, 0);
    chk("rst_dout", dout_d, 0);
    chk("rst_ovf", ovf_d, 0);
    push(1'b1, 1'b1, 11'd2047, 9'd511);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      chk($sformatf("lat2_k%0d", k), ov_d, 32'(k == 3));
      chk($sformatf("lat1_k%0d", k), ov_1, 32'(k == 2));
      chk($sformatf("lat4_k%0d", k), ov_4, 32'(k == 5));
    end
    chk("single_dout", dout_d, 1046017);
    chk("single_ovf", ovf_d, 0);
    chk("single_dout_ms1", dout_1, 1046017);
    chk("single_dout_ms4", dout_4, 1046017);
    for (int i = 0; i < 16; i++) push(i == 0, i == 15, 11'd2047, 9'd511);
    wait_out(0, 8);
    chk("run16_dout", dout_d, 16736272);
    chk("run16_ovf", ovf_d, 0);
    for (int i = 0; i < 17; i++) push(i == 0, i == 16, 11'd2047, 9'd511);
    wait_out(0, 8);
    chk("run17_dout", dout_d, 24'hFFFFFF);
    chk("run17_ovf", ovf_d, 1);
    push(1'b1, 1'b0, 11'h400, 9'd255);
    push(1'b0, 1'b0, 11'h400, 9'd255);
    push(1'b0, 1'b1, 11'd3, 9'd3);
    wait_out(1, 8);
    chk("sgn_mix_dout", dout_s, 24'hF80809);
    chk("sgn_mix_ovf", ovf_s, 0);
    for (int i = 0; i < 64; i++) push(i == 0, i == 63, 11'h400, 9'h100);
    wait_out(1, 8);
    chk("sgn_sat_dout", dout_s, 24'h7FFFFF);
    chk("sgn_sat_ovf", ovf_s, 1);
    tick(3);
    push(1'b1, 1'b1, 11'd5, 9'd7);
    push(1'b1, 1'b0, 11'd2, 9'd3);
    tick(1);
    push(1'b0, 1'b1, 11'd4, 9'd4);
    chk("b2b_first_valid", ov_d, 1);
    chk("b2b_first_dout", dout_d, 35);
    tick(2);
    chk("b2b_gap_valid", ov_d, 0);
    chk("b2b_gap_dout", dout_d, 35);
    tick(1);
    chk("b2b_second_valid", ov_d, 1);
    chk("b2b_second_dout", dout_d, 22);
    push(1'b1, 1'b1, 11'd5, 9'd7);
    tick(1);
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk("ce_frozen_valid", ov_d, 0);
      chk("ce_frozen_dout", dout_d, 22);
    end
    ce = 1'b1;
    tick(1);
    chk("ce_resume_early", ov_d, 0);
    tick(1);
    chk("ce_resume_valid", ov_d, 1);
    chk("ce_resume_dout", dout_d, 35);
    ce = 1'b0;
    tick(2);
    chk("ce_hold_pulse", ov_d, 1);
    ce = 1'b1;
    tick(1);
    chk("ce_pulse_drop", ov_d, 0);
    push(1'b1, 1'b0, 11'd9, 9'd9);
    push(1'b0, 1'b0, 11'd9, 9'd9);
    in_valid = 1'b1;
    in_last = 1'b1;
    ap_rst = 1'b1;
    tick(1);
    in_valid = 1'b0;
    in_last = 1'b0;
    ap_rst = 1'b0;
    chk("midrst_dout", dout_d, 0);
    chk("midrst_ovf", ovf_d, 0);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("midrst_no_valid", ov_d, 0);
    end
    push(1'b1, 1'b1, 11'd3, 9'd4);
    wait_out(0, 8);
    chk("post_rst_dout", dout_d, 12);
    push(1'b0, 1'b1, 11'd6, 9'd6);
    wait_out(0, 8);
    chk("nofirst_dout", dout_d, 36);
    push(1'b1, 1'b0, 11'd3, 9'd3);
    push(1'b1, 1'b1, 11'd1, 9'd1);
    wait_out(0, 8);
    chk("refirst_dout", dout_d, 1);
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk("refirst_single_pulse", ov_d, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cnn_mac_pipe.md
# cnn_mac_pipe

Parametrised, pipelined multiply-accumulate unit for the CNN convolution and dense datapaths, generalising the fixed 11x9 unsigned combinational multiplier. It registers the product through a configurable number of stages, optionally treats operands as signed, and accumulates a run of products framed by first/last flags into a saturating accumulator. It sits between the weight/feature-map buffers and the activation stage, producing one dot-product result per framed run.

## Interface
- A_WIDTH, 11, operand din0 width
- B_WIDTH, 9, operand din1 width
- ACC_WIDTH, 24, accumulator/result width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise)
- MUL_STAGES, 2, product pipeline register stages, 1..4
- SIGNED, 0, 0 = unsigned operands/saturation, 1 = two's-complement
- ap_clk  in  1  clock, all logic rising-edge
- ap_rst  in  1  reset, synchronous, active-high
- ce  in  1  global clock enable; 0 freezes every register
- in_valid  in  1  operand pair valid
- in_first  in  1  qualifies in_valid: first product of a run
- in_last  in  1  qualifies in_valid: last product of a run
- din0  in  A_WIDTH  operand A
- din1  in  B_WIDTH  operand B
- out_valid  out  1  one-cycle pulse, dout/out_ovf valid
- dout  out  ACC_WIDTH  accumulated result, held until next out_valid
- out_ovf  out  1  run saturated at least once

## Operation
- Product P = din0*din1, width A_WIDTH+B_WIDTH, signedness per SIGNED; sign/zero-extended to ACC_WIDTH before accumulation.
- Valid, first and last flags travel alongside P through MUL_STAGES registers.
- Accumulator stage (one register) on a valid product: first=1 -> acc = P, ovf = 0; else acc = sat(acc + P), ovf |= overflow.
- Saturation: unsigned clamps to 2^ACC_WIDTH-1; signed clamps to +2^(ACC_WIDTH-1)-1 / -2^(ACC_WIDTH-1). Overflow detected on the ACC_WIDTH+1-bit sum.
- last=1 on a valid product: dout <= updated acc value, out_ovf <= updated ovf, out_valid pulses; acc and ovf then clear to 0.
- first and last together: single-product run, dout = P, out_ovf = 0.
- in_valid=0 inserts a bubble; acc holds, no output.
- first arriving mid-run discards the partial sum silently (no out_valid).
- Valid product without a preceding first after reset or after a last accumulates onto 0.
- in_first/in_last ignored when in_valid=0.
- No backpressure: a new operand may be accepted every ce=1 cycle.

## Timing
- Reset (ap_rst=1 at edge, regardless of ce): all pipeline valids, acc, ovf, dout, out_ovf, out_valid to 0; in-flight runs are lost.
- Latency: operand accepted at edge N with last=1 -> out_valid high after edge N+MUL_STAGES+1 (cycle count counts only ce=1 edges).
- Throughput: 1 operand/cycle; back-to-back runs allowed (last at N, first at N+1) with no bubble; out_valid may be high in consecutive cycles.
- ce=0: all state including out_valid holds; a pulsing out_valid stays high until the next ce=1 edge.
- dout and out_ovf change only on out_valid edges or reset.

## Structure
- Package cnn_mac_pkg: saturation-limit functions sat_max(ACC_WIDTH, SIGNED)/sat_min(...), and MUL_STAGES range constants.
- Sub-module cnn_mac_pipe_mul: parametrised pipelined multiplier with sideband flag pipeline (A_WIDTH, B_WIDTH, MUL_STAGES, SIGNED, flag width); maps onto DSP48 registers.
- Top holds accumulator, saturation and output registers only.

## Test plan
- Defaults, single run first+last din0=2047, din1=511 -> out_valid 3 cycles later, dout=1046017, out_ovf=0.
- Defaults, 16 consecutive 2047x511 products framed first..last -> dout=16736272, out_ovf=0; 17 products -> dout=16777215, out_ovf=1.
- SIGNED=1, run of (-1024x255),(-1024x255),(3x3) -> dout=-522231; 64 products of -1024x-256 -> dout=8388607, out_ovf=1.
- Back-to-back runs {5x7} then {2x3,4x4} with no gap, plus a bubble inside the second -> out_valid pulses give 35 then 22.
- ce held low 5 cycles mid-pipeline -> outputs frozen, result and latency shift by exactly 5; ap_rst asserted mid-run -> no out_valid, dout=0, next run correct from scratch.
- first reasserted mid-run (3x3, then first 1x1 last) -> only output dout=1; MUL_STAGES=1 and 4 rerun scenario 1 with latency 2 and 5.
